// File: rtl/mmio_host_sequencer.sv
// Host-side MMIO sequencer: programs the AFU job registers, kicks go, then polls
// the done register until completion or until the per-job poll limit is reached.
module mmio_host_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned SIZE_WIDTH    = 32,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned RD_LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_rd_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic [SIZE_WIDTH-1:0] cfg_input_size,
    input  logic [SIZE_WIDTH-1:0] cfg_output_size,
    input  logic [15:0]           timeout_limit,
    output logic                  busy,
    output logic                  complete,
    output logic                  timeout_err,
    output logic [15:0]           poll_count,
    output logic                  mmio_wr_en,
    output logic [15:0]           mmio_wr_addr,
    output logic [63:0]           mmio_wr_data,
    output logic                  mmio_rd_en,
    output logic [15:0]           mmio_rd_addr,
    input  logic [63:0]           mmio_rd_data
);

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_RDA  = 4'd1;
    localparam logic [3:0] S_WR_WRA  = 4'd2;
    localparam logic [3:0] S_WR_ISZ  = 4'd3;
    localparam logic [3:0] S_WR_OSZ  = 4'd4;
    localparam logic [3:0] S_WR_GO   = 4'd5;
    localparam logic [3:0] S_GAP     = 4'd6;
    localparam logic [3:0] S_RD_REQ  = 4'd7;
    localparam logic [3:0] S_RD_WAIT = 4'd8;

    localparam logic [15:0] REG_GO       = 16'h0050;
    localparam logic [15:0] REG_RD_ADDR  = 16'h0052;
    localparam logic [15:0] REG_WR_ADDR  = 16'h0054;
    localparam logic [15:0] REG_IN_SIZE  = 16'h0056;
    localparam logic [15:0] REG_OUT_SIZE = 16'h0058;
    localparam logic [15:0] REG_DONE     = 16'h005A;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

    logic [3:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
    logic [SIZE_WIDTH-1:0] in_size_q, in_size_nxt;
    logic [SIZE_WIDTH-1:0] out_size_q, out_size_nxt;
    logic [15:0]           limit_q, limit_nxt;
    logic [15:0]           poll_nxt;
    logic                  busy_nxt, complete_nxt, timeout_nxt;
    logic                  wr_en_nxt, rd_en_nxt;
    logic [15:0]           wr_addr_out_nxt, rd_addr_out_nxt;
    logic [63:0]           wr_data_nxt;
    logic                  unused_rd_bits;

    // Only the done flag in bit 0 carries meaning.
    assign unused_rd_bits = ^mmio_rd_data[63:1];

    // Next-state, capture and poll bookkeeping.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_addr_nxt  = rd_addr_q;
        wr_addr_nxt  = wr_addr_q;
        in_size_nxt  = in_size_q;
        out_size_nxt = out_size_q;
        limit_nxt    = limit_q;
        poll_nxt     = poll_count;
        complete_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    rd_addr_nxt  = cfg_rd_addr;
                    wr_addr_nxt  = cfg_wr_addr;
                    in_size_nxt  = cfg_input_size;
                    out_size_nxt = cfg_output_size;
                    limit_nxt    = timeout_limit;
                    poll_nxt     = 16'd0;
                    state_nxt    = S_WR_RDA;
                end
            end
            S_WR_RDA: state_nxt = S_WR_WRA;
            S_WR_WRA: state_nxt = S_WR_ISZ;
            S_WR_ISZ: state_nxt = S_WR_OSZ;
            S_WR_OSZ: state_nxt = S_WR_GO;
            S_WR_GO: begin
                cnt_nxt   = '0;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_RD_REQ;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RD_REQ: begin
                if (poll_count != 16'hFFFF) begin
                    poll_nxt = poll_count + 16'd1;
                end
                cnt_nxt   = '0;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nxt = '0;
                    if (mmio_rd_data[0]) begin
                        complete_nxt = 1'b1;
                        state_nxt    = S_IDLE;
                    end else if (limit_q != 16'd0 && poll_count == limit_q) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        wr_en_nxt       = 1'b0;
        wr_addr_out_nxt = 16'd0;
        wr_data_nxt     = 64'd0;
        rd_en_nxt       = 1'b0;
        rd_addr_out_nxt = 16'd0;
        busy_nxt        = (state_nxt != S_IDLE);
        case (state_nxt)
            S_WR_RDA: begin
                wr_en_nxt       = 1'b1;
                wr_addr_out_nxt = REG_RD_ADDR;
                wr_data_nxt     = 64'(rd_addr_nxt);
            end
            S_WR_WRA: begin
                wr_en_nxt       = 1'b1;
                wr_addr_out_nxt = REG_WR_ADDR;
                wr_data_nxt     = 64'(wr_addr_nxt);
            end
            S_WR_ISZ: begin
                wr_en_nxt       = 1'b1;
                wr_addr_out_nxt = REG_IN_SIZE;
                wr_data_nxt     = 64'(in_size_nxt);
            end
            S_WR_OSZ: begin
                wr_en_nxt       = 1'b1;
                wr_addr_out_nxt = REG_OUT_SIZE;
                wr_data_nxt     = 64'(out_size_nxt);
            end
            S_WR_GO: begin
                wr_en_nxt       = 1'b1;
                wr_addr_out_nxt = REG_GO;
                wr_data_nxt     = 64'h1;
            end
            S_RD_REQ: begin
                rd_en_nxt       = 1'b1;
                rd_addr_out_nxt = REG_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            in_size_q    <= '0;
            out_size_q   <= '0;
            limit_q      <= 16'd0;
            poll_count   <= 16'd0;
            busy         <= 1'b0;
            complete     <= 1'b0;
            timeout_err  <= 1'b0;
            mmio_wr_en   <= 1'b0;
            mmio_wr_addr <= 16'd0;
            mmio_wr_data <= 64'd0;
            mmio_rd_en   <= 1'b0;
            mmio_rd_addr <= 16'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rd_addr_q    <= rd_addr_nxt;
            wr_addr_q    <= wr_addr_nxt;
            in_size_q    <= in_size_nxt;
            out_size_q   <= out_size_nxt;
            limit_q      <= limit_nxt;
            poll_count   <= poll_nxt;
            busy         <= busy_nxt;
            complete     <= complete_nxt;
            timeout_err  <= timeout_nxt;
            mmio_wr_en   <= wr_en_nxt;
            mmio_wr_addr <= wr_addr_out_nxt;
            mmio_wr_data <= wr_data_nxt;
            mmio_rd_en   <= rd_en_nxt;
            mmio_rd_addr <= rd_addr_out_nxt;
        end
    end

endmodule

// File: tb/tb_mmio_host_sequencer.sv
// Bench for mmio_host_sequencer: directed and randomized jobs against an event-schedule
// model, with a done-register responder that only shows the true flag on the valid cycle.
module tb_mmio_host_sequencer;

    localparam int AW = 48;
    localparam int SW = 16;
    localparam int PI = 4;
    localparam int L  = 2;

    typedef struct packed {
        int          cyc;
        logic [15:0] addr;
        logic [63:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_rd_addr = '0;
    logic [AW-1:0] cfg_wr_addr = '0;
    logic [SW-1:0] cfg_input_size = '0;
    logic [SW-1:0] cfg_output_size = '0;
    logic [15:0]   timeout_limit = '0;
    logic          busy, complete, timeout_err;
    logic [15:0]   poll_count;
    logic          mmio_wr_en, mmio_rd_en;
    logic [15:0]   mmio_wr_addr, mmio_rd_addr;
    logic [63:0]   mmio_wr_data;
    logic [63:0]   mmio_rd_data;

    mmio_host_sequencer #(
        .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .POLL_INTERVAL(PI), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_rd_addr(cfg_rd_addr), .cfg_wr_addr(cfg_wr_addr),
        .cfg_input_size(cfg_input_size), .cfg_output_size(cfg_output_size),
        .timeout_limit(timeout_limit),
        .busy(busy), .complete(complete), .timeout_err(timeout_err), .poll_count(poll_count),
        .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_data(mmio_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ev_t wq[$];
    ev_t rq[$];
    ev_t bq[$];
    int  cq[$];
    int  tq[$];
    int  idle_bad = 0;
    int  overlap = 0;
    int  job_id = 0;
    int  job_seen = 0;
    int  rd_cnt = 0;
    int  last_rd = 0;
    int  done_after = 1;
    logic prev_busy = 1'b0;

    // Mid-cycle monitor and done-register responder.
    always @(negedge clk) begin
        bit cur;
        logic [63:0] rdata;
        if (job_seen != job_id) begin
            job_seen = job_id;
            rd_cnt = 0;
        end
        if (mmio_wr_en) wq.push_back(ev_t'{cyc, mmio_wr_addr, mmio_wr_data});
        else if (mmio_wr_addr != 16'd0 || mmio_wr_data != 64'd0) idle_bad++;
        if (mmio_rd_en) begin
            rq.push_back(ev_t'{cyc, mmio_rd_addr, 64'd0});
            rd_cnt++;
            last_rd = cyc;
        end else if (mmio_rd_addr != 16'd0) idle_bad++;
        if (mmio_wr_en && mmio_rd_en) overlap++;
        if (complete) cq.push_back(cyc);
        if (timeout_err) tq.push_back(cyc);
        if (busy !== prev_busy) begin
            bq.push_back(ev_t'{cyc, 16'd0, 64'(busy)});
            prev_busy = busy;
        end
        cur = (done_after != 0) && (rd_cnt >= done_after);
        rdata = {$urandom, $urandom};
        rdata[0] = (rd_cnt > 0 && cyc == last_rd + L) ? cur : !cur;
        mmio_rd_data = rdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; start is sampled at the next edge.
    task automatic launch(input logic [63:0] rd, input logic [63:0] wr, input logic [63:0] isz,
                          input logic [63:0] osz, input int nd, input int lim, output int t);
        cfg_rd_addr     = rd[AW-1:0];
        cfg_wr_addr     = wr[AW-1:0];
        cfg_input_size  = isz[SW-1:0];
        cfg_output_size = osz[SW-1:0];
        timeout_limit   = 16'(lim);
        done_after      = nd;
        job_id++;
        start = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_rd_addr     = AW'({$urandom, $urandom});
        cfg_wr_addr     = AW'({$urandom, $urandom});
        cfg_input_size  = SW'($urandom);
        cfg_output_size = SW'($urandom);
        timeout_limit   = 16'($urandom);
    endtask

    task automatic check_job(input string nm, input int t, input int nd, input int lim,
                             input logic [63:0] rd, input logic [63:0] wr,
                             input logic [63:0] isz, input logic [63:0] osz);
        int n, e, idx;
        bit is_done;
        logic [15:0] wa[5];
        logic [63:0] wd[5];
        if (nd != 0 && (lim == 0 || nd <= lim)) begin n = nd; is_done = 1'b1; end
        else begin n = lim; is_done = 1'b0; end
        e = t + 6 + PI + (n - 1) * (L + 1 + PI) + L + 1;
        wa[0] = 16'h0052; wa[1] = 16'h0054; wa[2] = 16'h0056; wa[3] = 16'h0058; wa[4] = 16'h0050;
        wd[0] = rd; wd[1] = wr; wd[2] = isz; wd[3] = osz; wd[4] = 64'h1;
        while (cyc < e + PI + L + 4) @(posedge clk);
        #1;
        idx = 0;
        foreach (wq[i]) if (wq[i].cyc > t) begin
            if (idx < 5) begin
                check({nm, " write cycle"}, 64'(wq[i].cyc), 64'(t + 1 + idx));
                check({nm, " write addr"}, 64'(wq[i].addr), 64'(wa[idx]));
                check({nm, " write data"}, wq[i].data, wd[idx]);
            end
            idx++;
        end
        check({nm, " write count"}, 64'(idx), 64'd5);
        idx = 0;
        foreach (rq[i]) if (rq[i].cyc > t) begin
            check({nm, " read cycle"}, 64'(rq[i].cyc), 64'(t + 6 + PI + idx * (L + 1 + PI)));
            check({nm, " read addr"}, 64'(rq[i].addr), 64'h005A);
            idx++;
        end
        check({nm, " read count"}, 64'(idx), 64'(n));
        idx = 0;
        foreach (cq[i]) if (cq[i] > t) begin
            check({nm, " complete cycle"}, 64'(cq[i]), 64'(e));
            idx++;
        end
        check({nm, " complete count"}, 64'(idx), 64'(is_done));
        idx = 0;
        foreach (tq[i]) if (tq[i] > t) begin
            check({nm, " timeout cycle"}, 64'(tq[i]), 64'(e));
            idx++;
        end
        check({nm, " timeout count"}, 64'(idx), 64'(!is_done));
        idx = 0;
        foreach (bq[i]) if (bq[i].cyc > t) begin
            if (idx < 2) begin
                check({nm, " busy edge cycle"}, 64'(bq[i].cyc), 64'(idx == 0 ? t + 1 : e));
                check({nm, " busy edge level"}, bq[i].data, 64'(idx == 0));
            end
            idx++;
        end
        check({nm, " busy edge count"}, 64'(idx), 64'd2);
        check({nm, " poll_count"}, 64'(poll_count), 64'(n));
        check({nm, " busy at end"}, 64'(busy), 64'd0);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, " busy"}, 64'(busy), 64'd0);
        check({nm, " complete"}, 64'(complete), 64'd0);
        check({nm, " timeout_err"}, 64'(timeout_err), 64'd0);
        check({nm, " poll_count"}, 64'(poll_count), 64'd0);
        check({nm, " wr_en"}, 64'(mmio_wr_en), 64'd0);
        check({nm, " wr_addr"}, 64'(mmio_wr_addr), 64'd0);
        check({nm, " wr_data"}, mmio_wr_data, 64'd0);
        check({nm, " rd_en"}, 64'(mmio_rd_en), 64'd0);
        check({nm, " rd_addr"}, 64'(mmio_rd_addr), 64'd0);
    endtask

    function automatic logic [63:0] rnd_addr();
        return 64'({$urandom, $urandom}) & 64'h0000_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        int t, t2, nd, lim, e1, cnt;
        logic [63:0] rd, wr, isz, osz;

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic single-poll job.
        launch(64'h1000, 64'h2000, 64'd8, 64'd8, 1, 0, t);
        check_job("basic", t, 1, 0, 64'h1000, 64'h2000, 64'd8, 64'd8);

        // Done rises on the third read.
        rd = rnd_addr(); wr = rnd_addr(); isz = 64'($urandom_range(0, 65535)); osz = 64'($urandom_range(0, 65535));
        launch(rd, wr, isz, osz, 3, 0, t);
        check_job("multipoll", t, 3, 0, rd, wr, isz, osz);

        // Done never rises; limit of five reads.
        launch(64'h40, 64'h80, 64'd1, 64'd2, 0, 5, t);
        check_job("timeout", t, 0, 5, 64'h40, 64'h80, 64'd1, 64'd2);

        // Second start during WR_ISZ must be ignored.
        launch(64'hABC0, 64'hDEF0, 64'd3, 64'd4, 2, 0, t);
        @(posedge clk); #1;
        cfg_rd_addr = 48'h1111; cfg_wr_addr = 48'h2222;
        cfg_input_size = 16'h33; cfg_output_size = 16'h44; timeout_limit = 16'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_job("start_busy", t, 2, 0, 64'hABC0, 64'hDEF0, 64'd3, 64'd4);

        // Full-width values, zero extension, and high read-data bits ignored.
        launch(64'h0000_FFFF_FFFF_FFFF, 64'h0000_8000_0000_0001, 64'hFFFF, 64'h0, 2, 0, t);
        check_job("width", t, 2, 0, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_8000_0000_0001,
                  64'h0000_0000_0000_FFFF, 64'h0);

        // Reset asserted during GAP aborts the job.
        launch(64'h5000, 64'h6000, 64'd7, 64'd9, 1, 0, t);
        while (cyc < t + 8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_quiet("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (PI + L + 20) @(posedge clk);
        #1;
        cnt = 0;
        foreach (rq[i]) if (rq[i].cyc > t) cnt++;
        check("midreset reads", 64'(cnt), 64'd0);
        cnt = 0;
        foreach (wq[i]) if (wq[i].cyc > t + 8) cnt++;
        check("midreset late writes", 64'(cnt), 64'd0);
        cnt = 0;
        foreach (cq[i]) if (cq[i] > t) cnt++;
        foreach (tq[i]) if (tq[i] > t) cnt++;
        check("midreset pulses", 64'(cnt), 64'd0);
        launch(64'h7000, 64'h8000, 64'd5, 64'd6, 1, 0, t);
        check_job("after_reset", t, 1, 0, 64'h7000, 64'h8000, 64'd5, 64'd6);

        // Start in the same cycle as the complete pulse.
        launch(64'h100, 64'h200, 64'd1, 64'd1, 1, 0, t);
        e1 = t + 6 + PI + L + 1;
        cnt = 0;
        while (complete !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("chain first complete cycle", 64'(cyc), 64'(e1));
        rd = rnd_addr(); wr = rnd_addr();
        launch(rd, wr, 64'd11, 64'd12, 2, 0, t2);
        check_job("chain second", t2, 2, 0, rd, wr, 64'd11, 64'd12);

        // Randomized jobs, mixing completion and timeout outcomes.
        for (int j = 0; j < 8; j++) begin
            rd = rnd_addr(); wr = rnd_addr();
            isz = 64'($urandom_range(0, 65535)); osz = 64'($urandom_range(0, 65535));
            nd = $urandom_range(0, 4);
            lim = $urandom_range(0, 4);
            if (nd == 0 && lim == 0) lim = 3;
            launch(rd, wr, isz, osz, nd, lim, t);
            check_job("random", t, nd, lim, rd, wr, isz, osz);
        end

        check("strobe overlap", 64'(overlap), 64'd0);
        check("idle addr/data nonzero", 64'(idle_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_host_sequencer.md
# mmio_host_sequencer

Initiator-side MMIO sequencer for the pipeline's memory map. It accepts one job descriptor (read address, write address, input and output sizes) and issues the MMIO register writes that configure and start the AFU. It then polls the done register until completion or timeout. It drives the host end of the same register protocol: in simulation benches it stands in for software, and in hardware it acts as an on-chip controller.

## Interface
- ADDR_WIDTH, 64, width of cfg_rd_addr/cfg_wr_addr (≤64)
- SIZE_WIDTH, 32, width of cfg_input_size/cfg_output_size (≤64)
- POLL_INTERVAL, 16, idle cycles before each done read (≥1)
- RD_LATENCY, 1, cycles from mmio_rd_en to valid mmio_rd_data (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch job; honoured only in IDLE
- cfg_rd_addr  in  ADDR_WIDTH  DMA read byte address
- cfg_wr_addr  in  ADDR_WIDTH  DMA write byte address
- cfg_input_size  in  SIZE_WIDTH  input cache lines
- cfg_output_size  in  SIZE_WIDTH  output cache lines
- timeout_limit  in  16  max done reads per job; 0 = unlimited; sampled at start
- busy  out  1  job in progress
- complete  out  1  one-cycle pulse, done observed
- timeout_err  out  1  one-cycle pulse, poll limit reached
- poll_count  out  16  done reads issued this job, saturating
- mmio_wr_en  out  1  register write strobe
- mmio_wr_addr  out  16  register write address
- mmio_wr_data  out  64  register write data
- mmio_rd_en  out  1  register read strobe
- mmio_rd_addr  out  16  register read address
- mmio_rd_data  in  64  register read data

## Operation
- Register map: go h0050, rd_addr h0052, wr_addr h0054, input_size h0056, output_size h0058, done h005A (bit 0).
- States: IDLE, WR_RDA, WR_WRA, WR_ISZ, WR_OSZ, WR_GO, GAP, RD_REQ, RD_WAIT.
- IDLE: on start, capture all cfg_* and timeout_limit, clear poll_count, go to WR_RDA. busy=0.
- WR_RDA → WR_WRA → WR_ISZ → WR_OSZ → WR_GO: each state is exactly one cycle with mmio_wr_en=1. Address is h0052, h0054, h0056, h0058, h0050 respectively. Data is the captured value zero-extended to 64 bits; go data = 64'h1.
- GAP: count POLL_INTERVAL cycles, then go to RD_REQ.
- RD_REQ: one cycle, mmio_rd_en=1, mmio_rd_addr=h005A; poll_count increments (saturating at hFFFF); go to RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles, then sample mmio_rd_data[0] and resolve:
  - bit=1: pulse complete, go to IDLE.
  - bit=0 and timeout_limit≠0 and poll_count==timeout_limit: pulse timeout_err, go to IDLE.
  - otherwise: go to GAP.
- start outside IDLE is ignored; captured cfg values are unaffected.
- mmio_rd_data bits [63:1] are ignored.
- Idle values: mmio_wr_en=0, mmio_rd_en=0; addr/data outputs drive 0 whenever their strobe is low.

## Timing
- Reset values: busy=0, complete=0, timeout_err=0, poll_count=0, all mmio_* outputs 0, state IDLE.
- Assertion of rst mid-job aborts immediately. No further strobes are issued and no complete or timeout_err pulse is produced. The AFU side is not cleaned up.
- Write schedule: with start sampled at edge T, the five writes occupy cycles T+1…T+5. busy is high from T+1.
- Read schedule: the first mmio_rd_en occurs at cycle R = T+6+POLL_INTERVAL. mmio_rd_data is sampled at R+RD_LATENCY. complete or timeout_err is high at R+RD_LATENCY+1, busy is 0 in that same cycle, and state is IDLE.
- Repoll spacing: each later read follows the previous one by RD_LATENCY+1+POLL_INTERVAL cycles.
- A start asserted in the same cycle as the complete pulse is accepted, since state is already IDLE. Its first write lands on the next cycle.
- poll_count holds its final value in IDLE until the next accepted start.
- No write and read strobe are ever high in the same cycle.

## Test plan
- Basic job: start with rd=h1000, wr=h2000, isz=8, osz=8, POLL_INTERVAL=4; responder done=1 → writes (h0052,h1000), (h0054,h2000), (h0056,8), (h0058,8), (h0050,1) on T+1..T+5; read h005A at T+10; complete at T+12; poll_count=1.
- Multi-poll: done rises after the 3rd read → exactly 3 reads spaced RD_LATENCY+1+POLL_INTERVAL apart; complete once; poll_count=3.
- Timeout: timeout_limit=5, done stuck 0 → 5 reads, then timeout_err pulse, complete never asserted, busy drops, poll_count=5.
- Start while busy: second start during WR_ISZ with different cfg → ignored; writes carry the first job's values.
- Reset mid-job: rst asserted during GAP → next cycle all outputs 0; no strobes afterward; a new start after deassertion runs a full sequence.
- Width/extension: SIZE_WIDTH=16, isz=hFFFF, ADDR_WIDTH=48, rd=all ones → wr_data h000000000000FFFF and h0000FFFFFFFFFFFF; mmio_rd_data=hFFFF_FFFF_FFFF_FFFE treated as not done.
